// File: rtl/serial_bit_tx.sv
// rtl/serial_bit_tx.sv - parallel-to-serial bit transmitter (start, LSB-first data, optional parity via TX_PARITY_EN, stop)
module serial_bit_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT == 1) ? 1 : $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;
`endif

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                tx_out_q, tx_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;
`ifdef TX_PARITY_EN
  logic                parity_q, parity_d;
`endif

  assign tx_ready = (state_q == IDLE);
  assign tx_out   = tx_out_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign bit_end  = (cnt_q == CNT_LAST);

  // Next state, datapath and registered-output values for the following cycle
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    tx_out_d = 1'b1;
    busy_d   = 1'b1;
    done_d   = 1'b0;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (tx_valid) begin
          shift_d  = tx_data;
          cnt_d    = '0;
          bit_d    = '0;
          state_d  = START;
          tx_out_d = 1'b0;
          busy_d   = 1'b1;
`ifdef TX_PARITY_EN
          parity_d = ^tx_data;
`endif
        end
      end
      START: begin
        tx_out_d = 1'b0;
        if (bit_end) begin
          cnt_d    = '0;
          state_d  = DATA;
          tx_out_d = shift_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        tx_out_d = shift_q[0];
        if (bit_end) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
`ifdef TX_PARITY_EN
            state_d  = PARITY;
            tx_out_d = parity_q;
`else
            state_d  = STOP;
            tx_out_d = 1'b1;
`endif
          end else begin
            bit_d    = bit_q + BIT_W'(1);
            tx_out_d = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef TX_PARITY_EN
      PARITY: begin
        tx_out_d = parity_q;
        if (bit_end) begin
          cnt_d    = '0;
          state_d  = STOP;
          tx_out_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        tx_out_d = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset returns the line to idle-high
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      bit_q    <= '0;
      tx_out_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      tx_out_q <= tx_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_serial_bit_tx.sv
// tb/tb_serial_bit_tx.sv - randomized self-checking bench for serial_bit_tx against a frame-level model
module tb_serial_bit_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
`ifdef TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NBITS     = DW + 2 + PAR;
  localparam int FRAME_CYC = NBITS * CPB;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, tx_out, tx_busy, tx_done;

  int n_checks = 0;
  int n_errors = 0;

  serial_bit_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line level for frame bit k: start, data LSB-first, optional even parity, stop
  function automatic logic exp_bit(input logic [DW-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    if (PAR == 1 && k == DW + 1) return 1'($countones(d) % 2);
    return 1'b1;
  endfunction

  function automatic logic [31:0] obs();
    return {28'd0, tx_out, tx_busy, tx_done, tx_ready};
  endfunction

  // Called at a negedge where the DUT is idle (or in its done cycle); returns at the done-cycle negedge.
  // mode 0: quiet inputs, 1: toggle valid with data FF, 2: random valid/data while busy
  task automatic run_frame(input logic [DW-1:0] d, input int mode, input string tag);
    check({tag, "_ready"}, {31'd0, tx_ready}, 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= FRAME_CYC; c++) begin
      @(negedge clk);
      case (mode)
        1:       begin tx_valid = ~tx_valid; tx_data = 8'hFF; end
        2:       begin tx_valid = 1'($urandom_range(0, 1)); tx_data = DW'($urandom); end
        default: tx_valid = 1'b0;
      endcase
      check($sformatf("%s_c%0d", tag, c), obs(), {28'd0, exp_bit(d, (c - 1) / CPB), 3'b100});
    end
    @(negedge clk);
    tx_valid = 1'b0;
    check({tag, "_done"}, obs(), 32'b1011);
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tx_valid = 1'b0;
      check($sformatf("%s_idle%0d", tag, i), obs(), 32'b1001);
    end
  endtask

  initial begin
    logic [DW-1:0] d;
    int            mode;
    int            gap;

    // Reset state and quiet idle
    repeat (3) @(negedge clk);
    check("rst_held", obs(), 32'b1001);
    resetn = 1'b1;
    idle_cycles(20, "rst");

    // Directed single frame
    run_frame(8'hA5, 0, "a5");
    idle_cycles(2, "a5");

    // Back-to-back: second word offered in the done cycle
    run_frame(8'h00, 0, "b2b0");
    run_frame(8'hFF, 0, "b2b1");
    idle_cycles(1, "b2b");

    // Input disturbance while busy is ignored
    run_frame(8'h3C, 1, "dist");
    idle_cycles(1, "dist");

    // Asynchronous reset mid-DATA
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    check("mid_bit1", obs(), {28'd0, exp_bit(8'h55, 2), 3'b100});
    resetn = 1'b0;
    #1;
    check("async_rst", obs(), 32'b1001);
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_hold%0d", i), obs(), 32'b1001);
    end
    tx_valid = 1'b0;
    resetn   = 1'b1;
    idle_cycles(3, "rel");
    run_frame(8'h81, 0, "x81");

    // Randomized frames with random gaps (gap 0 = back-to-back)
    for (int i = 0; i < 20; i++) begin
      d    = DW'($urandom);
      mode = (($urandom_range(0, 1)) == 1) ? 2 : 0;
      gap  = int'($urandom_range(0, 2));
      run_frame(d, mode, $sformatf("rnd%0d", i));
      idle_cycles(gap, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
